// File: rtl/score_argmax_seq_if.sv
// Score handoff from full_layer2 into the argmax stage, plus its result/status outputs.
// Pure wiring: no latency; there is no backpressure, so a capture request while busy is flagged as overrun.
interface score_argmax_seq_if #(
    parameter int N_CLASS = 10,
    parameter int DW      = 16,
    parameter int IW      = 4
);
    logic                          start;
    logic                          ready;
    logic [N_CLASS:1][DW-1:0]      input_feature;
    logic [IW-1:0]                 categories;
    logic [DW-1:0]                 margin;
    logic                          one_end;
    logic                          busy;
    logic                          overrun;

    modport master (
        output start, ready, input_feature,
        input  categories, margin, one_end, busy, overrun
    );

    modport slave (
        input  start, ready, input_feature,
        output categories, margin, one_end, busy, overrun
    );
endinterface

// File: rtl/score_argmax_seq.sv
// Serial argmax over N_CLASS signed scores: reports winner index, winner-minus-runner-up margin and a done pulse.
// Latency N_CLASS cycles from the ready edge to one_end; no backpressure, a ready while busy only sets overrun.
module score_argmax_seq #(
    parameter int N_CLASS = 10,
    parameter int DW      = 16,
    parameter int IW      = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    score_argmax_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    state_t                   state_q, state_d;
    logic [N_CLASS:1][DW-1:0] shadow_q, shadow_d;
    logic signed [DW-1:0]     max_q, max_d;
    logic signed [DW-1:0]     second_q, second_d;
    logic [IW-1:0]            best_q, best_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [IW-1:0]            categories_q, categories_d;
    logic [DW-1:0]            margin_q, margin_d;
    logic                     one_end_q, one_end_d;
    logic                     overrun_q, overrun_d;

    logic                     capture;
    logic signed [DW-1:0]     cur;

    assign capture = bus.start && bus.ready && (state_q == IDLE);

    always_comb begin
        cur = '0;
        for (int k = 1; k <= N_CLASS; k++) begin
            if (ptr_q == IW'(k)) cur = shadow_q[k];
        end
    end

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; dropping start aborts from anywhere
    always_comb begin
        state_d = state_q;
        if (!bus.start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.ready) state_d = (N_CLASS > 1) ? SCAN : DONE;
                SCAN:    if (ptr_q == IW'(N_CLASS)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.categories = categories_q;
        bus.margin     = margin_q;
        bus.one_end    = one_end_q;
        bus.overrun    = overrun_q;
    end

    always_comb begin
        shadow_d     = shadow_q;
        max_d        = max_q;
        second_d     = second_q;
        best_d       = best_q;
        ptr_d        = ptr_q;
        categories_d = categories_q;
        margin_d     = margin_q;
        one_end_d    = 1'b0;
        overrun_d    = overrun_q;

        if (capture) begin
            shadow_d = bus.input_feature;
            max_d    = bus.input_feature[1];
            best_d   = IW'(1);
            second_d = MOST_NEG;
            ptr_d    = IW'(2);
        end else if (bus.start && state_q == SCAN) begin
            // Strict compare keeps the lowest index on ties
            if (cur > max_q) begin
                second_d = max_q;
                max_d    = cur;
                best_d   = ptr_q;
            end else if (cur > second_q) begin
                second_d = cur;
            end
            ptr_d = ptr_q + IW'(1);
        end

        if (bus.start && state_q == DONE) begin
            categories_d = best_q - IW'(1);
            // max >= second, so the true difference fits DW unsigned bits and the modular result is exact
            margin_d     = $unsigned(max_q - second_q);
            one_end_d    = 1'b1;
        end

        if (!bus.start)                          overrun_d = 1'b0;
        else if (bus.ready && state_q != IDLE)   overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shadow_q     <= '0;
            max_q        <= '0;
            second_q     <= '0;
            best_q       <= '0;
            ptr_q        <= '0;
            categories_q <= '0;
            margin_q     <= '0;
            one_end_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            max_q        <= max_d;
            second_q     <= second_d;
            best_q       <= best_d;
            ptr_q        <= ptr_d;
            categories_q <= categories_d;
            margin_q     <= margin_d;
            one_end_q    <= one_end_d;
            overrun_q    <= overrun_d;
        end
    end
endmodule

// File: tb/tb_score_argmax_seq.sv
// Directed bench for score_argmax_seq: hand-computed winners/margins, latency, overrun, abort and reset.
module tb_score_argmax_seq;
    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic clk;
    logic n_reset;
    int   n_tests;
    int   n_fail;
    int   sc [1:N];

    score_argmax_seq_if #(.N_CLASS(N), .DW(DW), .IW(IW)) bus ();

    score_argmax_seq #(.N_CLASS(N), .DW(DW), .IW(IW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present sc[] with ready for one edge, then scramble the bus to prove the shadow copy is used
    task automatic send;
        for (int k = 1; k <= N; k++) bus.input_feature[k] = 16'(sc[k]);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        for (int k = 1; k <= N; k++) bus.input_feature[k] = 16'(32767 - k);
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input int exp_cat, input int exp_margin);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.one_end && lat < 30) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, "_categories"}, bus.categories, exp_cat);
        chk({tag, "_margin"}, bus.margin, exp_margin);
        chk({tag, "_busy_at_end"}, bus.busy, 0);
    endtask

    task automatic set_all(input int v);
        for (int k = 1; k <= N; k++) sc[k] = v;
    endtask

    initial begin
        int seen;
        n_tests = 0;
        n_fail  = 0;
        n_reset = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        bus.input_feature = '0;
        tick();
        tick();
        chk("rst_categories", bus.categories, 0);
        chk("rst_margin", bus.margin, 0);
        chk("rst_one_end", bus.one_end, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        n_reset   = 1'b1;
        bus.start = 1'b1;
        tick();

        // Basic scan
        sc = '{5, -3, 100, 7, 0, 99, -50, 2, 1, 4};
        send();
        wait_result("basic", 10, 2, 1);
        tick();
        chk("basic_one_end_single", bus.one_end, 0);
        chk("basic_hold_categories", bus.categories, 2);

        // Ties and negatives
        set_all(-7);
        send();
        wait_result("all_neg7", 10, 0, 0);
        tick();
        set_all(-1);
        sc[4] = 300;
        sc[9] = 300;
        send();
        wait_result("tie300", 10, 3, 0);
        tick();

        // Extremes
        set_all(-32768);
        sc[10] = 32767;
        send();
        wait_result("extreme", 10, 9, 65535);
        tick();
        set_all(-32768);
        send();
        wait_result("all_min", 10, 0, 0);
        tick();

        // Overrun: second ready on the third edge after capture
        sc = '{5, -3, 100, 7, 0, 99, -50, 2, 1, 4};
        send();
        tick();
        tick();
        for (int k = 1; k <= N; k++) bus.input_feature[k] = 16'(k * 1000);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        chk("overrun_set", bus.overrun, 1);
        wait_result("overrun_first", 7, 2, 1);
        tick();
        chk("overrun_sticky", bus.overrun, 1);
        bus.start = 1'b0;
        tick();
        chk("overrun_cleared", bus.overrun, 0);

        // start low with ready: ignored entirely
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        chk("stop_ready_busy", bus.busy, 0);
        chk("stop_ready_overrun", bus.overrun, 0);
        bus.start = 1'b1;
        tick();

        // Abort during SCAN
        set_all(-32768);
        sc[10] = 32767;
        send();
        tick();
        tick();
        tick();
        bus.start = 1'b0;
        tick();
        chk("abort_busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.one_end) seen++;
            tick();
        end
        chk("abort_no_one_end", seen, 0);
        chk("abort_hold_categories", bus.categories, 2);
        chk("abort_hold_margin", bus.margin, 1);
        bus.start = 1'b1;
        tick();
        set_all(-1);
        sc[4] = 300;
        sc[9] = 250;
        send();
        wait_result("after_abort", 10, 3, 50);
        tick();

        // Async reset mid-SCAN
        sc = '{5, -3, 100, 7, 0, 99, -50, 2, 1, 4};
        send();
        tick();
        tick();
        #2;
        n_reset = 1'b0;
        #1;
        chk("arst_categories", bus.categories, 0);
        chk("arst_margin", bus.margin, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_one_end", bus.one_end, 0);
        tick();
        n_reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.one_end) seen++;
            tick();
        end
        chk("arst_no_one_end", seen, 0);

        // Back-to-back: second ready on the first IDLE cycle after the result
        sc = '{5, -3, 100, 7, 0, 99, -50, 2, 1, 4};
        send();
        wait_result("b2b_first", 10, 2, 1);
        sc = '{-20, -10, -30, -40, -5, -60, -70, -80, -90, -6};
        send();
        wait_result("b2b_second", 10, 4, 1);
        chk("b2b_overrun", bus.overrun, 0);
        tick();
        chk("b2b_one_end_single", bus.one_end, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
